regfile_dump_reader: RTL and testbench

REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

---
 rtl/regfile_dump_reader_if.sv | 25 ++
 rtl/regfile_dump_reader.sv | 85 ++++++++
 tb/tb_regfile_dump_reader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_if.sv
// rtl/regfile_dump_reader_if.sv - dump word stream between the reader and its consumer

interface regfile_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_addr;
  logic              dump_valid;
  logic              dump_ready;

  modport master (
    output dump_data,
    output dump_addr,
    output dump_valid,
    input  dump_ready
  );

  modport slave (
    input  dump_data,
    input  dump_addr,
    input  dump_valid,
    output dump_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a wrapping register range and streams each value out

module regfile_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] reg_rs,
  input  logic [DATA_W-1:0] rs_out,
  regfile_dump_reader_if.master dump,
  output logic              busy,
  output logic              done
);
  localparam int REM_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [REM_W-1:0]  remaining;
  logic [ADDR_W-1:0] span;

  // Modular difference so a first index above last wraps through the top entry.
  assign span   = last_addr - first_addr;
  assign reg_rs = (state == FETCH) ? ptr : '0;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      remaining       <= '0;
      dump.dump_data  <= '0;
      dump.dump_addr  <= '0;
      dump.dump_valid <= 1'b0;
      done            <= 1'b0;
    end else if (abort && state != IDLE) begin
      state           <= IDLE;
      dump.dump_valid <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            ptr       <= first_addr;
            remaining <= {1'b0, span} + REM_W'(1);
            state     <= FETCH;
          end
        end
        FETCH: begin
          dump.dump_data  <= rs_out;
          dump.dump_addr  <= ptr;
          dump.dump_valid <= 1'b1;
          state           <= HOLD;
        end
        HOLD: begin
          if (dump.dump_valid && dump.dump_ready) begin
            dump.dump_valid <= 1'b0;
            if (remaining == REM_W'(1)) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              remaining <= remaining - REM_W'(1);
              ptr       <= ptr + 1'b1;
              state     <= FETCH;
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - bench for regfile_dump_reader

module tb_regfile_dump_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  reg_rs;
  logic [31:0] rs_out;
  logic        busy;
  logic        done;
  logic [31:0] regs [32];

  int n_checks = 0;
  int n_fail   = 0;

  regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) dif ();

  regfile_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .reg_rs     (reg_rs),
    .rs_out     (rs_out),
    .dump       (dif.master),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  assign rs_out = regs[reg_rs];

  typedef struct {
    logic [4:0] f;
    logic [4:0] l;
    int         pct;
    bit         restart;
    int         words;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_done"}, done, 1'b0);
    check({name, "_valid"}, dif.dump_valid, 1'b0);
  endtask

  // One full dump: the model is the list of indices from f counting up mod 32 until l.
  task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int pct,
                         input bit restart, input int exp_words);
    logic [4:0] q[$];
    logic [4:0] a;
    int  cyc, accepts, fetch_cyc, last_acc;
    bit  done_seen, prev_valid, hs;
    a = f;
    q.push_back(a);
    while (a != l) begin
      a = a + 5'd1;
      q.push_back(a);
    end
    start = 1'b1; first_addr = f; last_addr = l; dif.dump_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    first_addr = 5'($urandom);
    last_addr  = 5'($urandom);
    cyc = 1; fetch_cyc = 1; accepts = 0; last_acc = -10;
    done_seen = 1'b0; prev_valid = 1'b0;
    while (!done_seen && cyc < 600) begin
      check("busy_during_dump", busy, 1'b1);
      if (cyc == fetch_cyc && q.size() > 0) check("reg_rs_fetch", reg_rs, q[0]);
      if (dif.dump_valid) begin
        if (q.size() == 0) begin
          check("extra_word", 1'b1, 1'b0);
        end else begin
          check("dump_addr", dif.dump_addr, q[0]);
          check("dump_data", dif.dump_data, regs[q[0]]);
          if (!prev_valid) check("valid_latency", cyc, fetch_cyc + 1);
        end
      end
      if (done) begin
        check("done_timing", cyc, last_acc + 1);
        check("word_count", accepts, exp_words);
        check("model_drained", q.size(), 0);
        done_seen = 1'b1;
      end
      if (restart && cyc == 3) begin
        start = 1'b1; first_addr = 5'($urandom); last_addr = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      dif.dump_ready = (pct >= 100) || ($urandom_range(99) < pct);
      hs = dif.dump_valid && dif.dump_ready;
      prev_valid = dif.dump_valid && !hs;
      @(negedge clk);
      if (hs && q.size() > 0) begin
        void'(q.pop_front());
        accepts++;
        last_acc  = cyc;
        fetch_cyc = cyc + 1;
      end
      cyc++;
    end
    if (!done_seen) check("dump_timeout", 1'b0, 1'b1);
    start = 1'b0; dif.dump_ready = 1'b0;
    check_idle("after_done");
  endtask

  vec_t tbl[7];

  initial begin
    int k;
    logic [4:0] rf, rl;
    tbl[0] = '{5'd3,  5'd5,  100, 1'b0, 3};
    tbl[1] = '{5'd30, 5'd1,  100, 1'b0, 4};
    tbl[2] = '{5'd7,  5'd6,  100, 1'b0, 32};
    tbl[3] = '{5'd9,  5'd9,  100, 1'b0, 1};
    tbl[4] = '{5'd0,  5'd31, 50,  1'b0, 32};
    tbl[5] = '{5'd31, 5'd0,  60,  1'b1, 2};
    tbl[6] = '{5'd12, 5'd20, 40,  1'b1, 9};

    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    rst = 1'b1; start = 1'b0; abort = 1'b0; dif.dump_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_data", dif.dump_data, 32'd0);
    check("reset_addr", dif.dump_addr, 5'd0);
    check("reset_reg_rs", reg_rs, 5'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      do_dump(tbl[i].f, tbl[i].l, tbl[i].pct, tbl[i].restart, tbl[i].words);

    // Consumer stall on word 4.
    start = 1'b1; first_addr = 5'd4; last_addr = 5'd4;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!dif.dump_valid && k < 5) begin @(negedge clk); k++; end
    check("stall_valid_rise", dif.dump_valid, 1'b1);
    for (int j = 0; j < 5; j++) begin
      check("stall_valid", dif.dump_valid, 1'b1);
      check("stall_data", dif.dump_data, 32'd4);
      check("stall_addr", dif.dump_addr, 5'd4);
      @(negedge clk);
    end
    dif.dump_ready = 1'b1;
    @(negedge clk);
    dif.dump_ready = 1'b0;
    check("stall_valid_drop", dif.dump_valid, 1'b0);
    check("stall_done", done, 1'b1);
    @(negedge clk);
    check_idle("stall_end");

    // Abort in HOLD of the second word, with ready also high.
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd5;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!dif.dump_valid && k < 5) begin @(negedge clk); k++; end
    dif.dump_ready = 1'b1;
    @(negedge clk);
    dif.dump_ready = 1'b0;
    @(negedge clk);
    check("abort_word2_valid", dif.dump_valid, 1'b1);
    check("abort_word2_addr", dif.dump_addr, 5'd1);
    abort = 1'b1; dif.dump_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; dif.dump_ready = 1'b0;
    check_idle("abort_hold");
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check_idle("abort_quiet");
    end

    // Abort together with start in IDLE, then abort in FETCH.
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_start_idle", busy, 1'b0);
    start = 1'b1; first_addr = 5'd2; last_addr = 5'd3;
    @(negedge clk);
    start = 1'b0;
    check("fetch_busy", busy, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort_fetch");

    // Reset mid-dump, with start and abort also high.
    start = 1'b1; first_addr = 5'd10; last_addr = 5'd20;
    @(negedge clk);
    start = 1'b0; dif.dump_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; abort = 1'b0; dif.dump_ready = 1'b0;
    check_idle("rst_mid");
    check("rst_mid_data", dif.dump_data, 32'd0);
    check("rst_mid_addr", dif.dump_addr, 5'd0);
    check("rst_mid_reg_rs", reg_rs, 5'd0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check_idle("rst_quiet");
    end
    do_dump(5'd3, 5'd5, 100, 1'b0, 3);

    // Random register contents, ranges and consumer back-pressure.
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int n = 0; n < 10; n++) begin
      rf = 5'($urandom);
      rl = 5'($urandom);
      do_dump(rf, rl, $urandom_range(20, 100), 1'($urandom_range(1)),
              ((int'(rl) - int'(rf) + 32) % 32) + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
